ofs_fim_eth_pause_ctrl: RTL and testbench

// Multi-channel flow-control generator for the Ethernet MAC sideband (t_eth_sideband_to_mac).

---
 rtl/ofs_fim_eth_pause_ctrl_if.sv | 33 +++
 rtl/ofs_fim_eth_pause_ctrl.sv | 138 +++++++++++++
 tb/tb_ofs_fim_eth_pause_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ofs_fim_eth_pause_ctrl_if.sv
// Flow-control sideband bundle: config and RX fill levels in, pause/PFC indications out.
// master drives config and fill levels; slave is the pause controller.
interface ofs_fim_eth_pause_ctrl_if #(
  parameter int NUM_CH    = 4,
  parameter int NUM_PRIO  = 8,
  parameter int FILL_W    = 12,
  parameter int REFRESH_W = 16,
  parameter int CNT_W     = 16
);
  logic                             cfg_enable;
  logic                             cfg_pfc_mode;
  logic [FILL_W-1:0]                cfg_xoff_thresh;
  logic [FILL_W-1:0]                cfg_xon_thresh;
  logic [REFRESH_W-1:0]             cfg_refresh_cycles;
  logic [NUM_CH*NUM_PRIO*FILL_W-1:0] rx_fill;
  logic [NUM_CH-1:0]                pause_xoff;
  logic [NUM_CH-1:0]                pause_xon;
  logic [NUM_CH*8-1:0]              pfc_xoff;
  logic [NUM_CH*NUM_PRIO-1:0]       xoff_state;
  logic [NUM_CH*CNT_W-1:0]          xoff_events;

  modport master (
    output cfg_enable, cfg_pfc_mode, cfg_xoff_thresh, cfg_xon_thresh,
           cfg_refresh_cycles, rx_fill,
    input  pause_xoff, pause_xon, pfc_xoff, xoff_state, xoff_events
  );

  modport slave (
    input  cfg_enable, cfg_pfc_mode, cfg_xoff_thresh, cfg_xon_thresh,
           cfg_refresh_cycles, rx_fill,
    output pause_xoff, pause_xon, pfc_xoff, xoff_state, xoff_events
  );
endinterface

// File: rtl/ofs_fim_eth_pause_ctrl.sv
// Per-channel link pause / PFC generator from RX fill levels with hysteresis and XOFF refresh.
// Fill to pause_xoff / pfc_xoff latency 2 cycles; no backpressure, pulses are issued unconditionally.
module ofs_fim_eth_pause_ctrl #(
  parameter int NUM_CH    = 4,
  parameter int NUM_PRIO  = 8,
  parameter int FILL_W    = 12,
  parameter int REFRESH_W = 16,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ofs_fim_eth_pause_ctrl_if.slave fc
);
  localparam int NP = NUM_CH * NUM_PRIO;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} fsm_e;

  logic [NP-1:0]        xoff_state_q, xoff_state_d;
  logic [NP-1:0]        pfc_q, pfc_d;
  logic [NUM_CH-1:0]    pause_xoff_q, pause_xoff_d;
  logic [NUM_CH-1:0]    pause_xon_q, pause_xon_d;
  fsm_e                 fsm_q   [NUM_CH];
  fsm_e                 fsm_d   [NUM_CH];
  logic [REFRESH_W-1:0] timer_q [NUM_CH];
  logic [REFRESH_W-1:0] timer_d [NUM_CH];
  logic [CNT_W-1:0]     evt_q   [NUM_CH];
  logic [CNT_W-1:0]     evt_d   [NUM_CH];

  logic [NUM_CH-1:0]       ch_xoff;
  logic [NUM_CH-1:0]       evt_inc;
  logic [NUM_CH-1:0]       busy;
  logic                    link_on;
  logic [FILL_W-1:0]       fill;
  logic [NUM_CH*8-1:0]     pfc_out;
  logic [NUM_CH*CNT_W-1:0] evt_out;

  // The "fill < xoff" release term keeps a misconfigured xon >= xoff from oscillating.
  always_comb begin
    fill         = '0;
    xoff_state_d = xoff_state_q;
    for (int i = 0; i < NP; i++) begin
      fill = fc.rx_fill[i*FILL_W +: FILL_W];
      if (!fc.cfg_enable)
        xoff_state_d[i] = 1'b0;
      else if (!xoff_state_q[i] && fill >= fc.cfg_xoff_thresh)
        xoff_state_d[i] = 1'b1;
      else if (xoff_state_q[i] && fill <= fc.cfg_xon_thresh && fill < fc.cfg_xoff_thresh)
        xoff_state_d[i] = 1'b0;
    end
    pfc_d   = fc.cfg_pfc_mode ? xoff_state_q : '0;
    ch_xoff = '0;
    pfc_out = '0;
    evt_out = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      ch_xoff[ch] = |xoff_state_q[ch*NUM_PRIO +: NUM_PRIO];
      for (int p = 0; p < NUM_PRIO; p++)
        pfc_out[ch*8+p] = pfc_q[ch*NUM_PRIO+p];
      evt_out[ch*CNT_W +: CNT_W] = evt_q[ch];
    end
  end

  // Any pulse in the previous cycle blocks a new one, guaranteeing an idle cycle between pulses.
  always_comb begin
    link_on      = fc.cfg_enable && !fc.cfg_pfc_mode;
    pause_xoff_d = '0;
    pause_xon_d  = '0;
    evt_inc      = '0;
    busy         = pause_xoff_q | pause_xon_q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      fsm_d[ch]   = fsm_q[ch];
      timer_d[ch] = timer_q[ch];
      case (fsm_q[ch])
        IDLE: begin
          if (link_on && ch_xoff[ch] && !busy[ch]) begin
            pause_xoff_d[ch] = 1'b1;
            timer_d[ch]      = fc.cfg_refresh_cycles;
            fsm_d[ch]        = HOLD;
            evt_inc[ch]      = 1'b1;
          end
        end
        HOLD: begin
          if (!link_on || !ch_xoff[ch]) begin
            if (!busy[ch]) begin
              pause_xon_d[ch] = 1'b1;
              timer_d[ch]     = '0;
              fsm_d[ch]       = IDLE;
            end
          end else if (fc.cfg_refresh_cycles != '0) begin
            if (timer_q[ch] <= REFRESH_W'(1)) begin
              if (!busy[ch]) begin
                pause_xoff_d[ch] = 1'b1;
                timer_d[ch]      = fc.cfg_refresh_cycles;
              end else begin
                timer_d[ch] = REFRESH_W'(1);
              end
            end else begin
              timer_d[ch] = timer_q[ch] - REFRESH_W'(1);
            end
          end
        end
        default: fsm_d[ch] = IDLE;
      endcase
      if (fc.cfg_pfc_mode && |(pfc_d[ch*NUM_PRIO +: NUM_PRIO] & ~pfc_q[ch*NUM_PRIO +: NUM_PRIO]))
        evt_inc[ch] = 1'b1;
      evt_d[ch] = (evt_inc[ch] && !(&evt_q[ch])) ? evt_q[ch] + CNT_W'(1) : evt_q[ch];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xoff_state_q <= '0;
      pfc_q        <= '0;
      pause_xoff_q <= '0;
      pause_xon_q  <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        fsm_q[ch]   <= IDLE;
        timer_q[ch] <= '0;
        evt_q[ch]   <= '0;
      end
    end else begin
      xoff_state_q <= xoff_state_d;
      pfc_q        <= pfc_d;
      pause_xoff_q <= pause_xoff_d;
      pause_xon_q  <= pause_xon_d;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        fsm_q[ch]   <= fsm_d[ch];
        timer_q[ch] <= timer_d[ch];
        evt_q[ch]   <= evt_d[ch];
      end
    end
  end

  assign fc.pause_xoff  = pause_xoff_q;
  assign fc.pause_xon   = pause_xon_q;
  assign fc.pfc_xoff    = pfc_out;
  assign fc.xoff_state  = xoff_state_q;
  assign fc.xoff_events = evt_out;
endmodule

// File: tb/tb_ofs_fim_eth_pause_ctrl.sv
// Directed bench for the pause controller: table-driven link-mode hysteresis plus hand sequences.
// Uses an 8-bit event counter so saturation is reachable in a short run.
module tb_ofs_fim_eth_pause_ctrl;
  localparam int NUM_CH    = 4;
  localparam int NUM_PRIO  = 8;
  localparam int FILL_W    = 12;
  localparam int REFRESH_W = 16;
  localparam int CNT_W     = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ofs_fim_eth_pause_ctrl_if #(.NUM_CH(NUM_CH), .NUM_PRIO(NUM_PRIO), .FILL_W(FILL_W),
                              .REFRESH_W(REFRESH_W), .CNT_W(CNT_W)) fc ();

  ofs_fim_eth_pause_ctrl #(.NUM_CH(NUM_CH), .NUM_PRIO(NUM_PRIO), .FILL_W(FILL_W),
                           .REFRESH_W(REFRESH_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fc    (fc)
  );

  typedef struct {
    logic [11:0] fill;
    logic        st;
    logic [3:0]  pxoff;
    logic [3:0]  pxon;
    logic [7:0]  evt;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fill(input int ch, input int p, input logic [11:0] v);
    fc.rx_fill[(ch*NUM_PRIO+p)*FILL_W +: FILL_W] = v;
  endtask

  function automatic logic [7:0] evt(input int ch);
    return fc.xoff_events[ch*CNT_W +: CNT_W];
  endfunction

  task automatic do_reset(input logic pfc, input logic [15:0] refresh,
                          input logic [11:0] xoff, input logic [11:0] xon);
    rst_n                 = 1'b0;
    fc.cfg_enable         = 1'b1;
    fc.cfg_pfc_mode       = pfc;
    fc.cfg_xoff_thresh    = xoff;
    fc.cfg_xon_thresh     = xon;
    fc.cfg_refresh_cycles = refresh;
    fc.rx_fill            = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    tbl[0]  = '{12'd0,    1'b0, 4'h0, 4'h0, 8'd0};
    tbl[1]  = '{12'd100,  1'b1, 4'h0, 4'h0, 8'd0};
    tbl[2]  = '{12'd100,  1'b1, 4'h1, 4'h0, 8'd1};
    tbl[3]  = '{12'd100,  1'b1, 4'h0, 4'h0, 8'd1};
    tbl[4]  = '{12'd60,   1'b1, 4'h0, 4'h0, 8'd1};
    tbl[5]  = '{12'd60,   1'b1, 4'h0, 4'h0, 8'd1};
    tbl[6]  = '{12'd50,   1'b0, 4'h0, 4'h0, 8'd1};
    tbl[7]  = '{12'd50,   1'b0, 4'h0, 4'h1, 8'd1};
    tbl[8]  = '{12'd50,   1'b0, 4'h0, 4'h0, 8'd1};
    tbl[9]  = '{12'd99,   1'b0, 4'h0, 4'h0, 8'd1};
    tbl[10] = '{12'd4095, 1'b1, 4'h0, 4'h0, 8'd1};
    tbl[11] = '{12'd0,    1'b0, 4'h1, 4'h0, 8'd2};
    tbl[12] = '{12'd0,    1'b0, 4'h0, 4'h0, 8'd2};
    tbl[13] = '{12'd0,    1'b0, 4'h0, 4'h1, 8'd2};
    tbl[14] = '{12'd0,    1'b0, 4'h0, 4'h0, 8'd2};

    // Reset values, checked while reset is still asserted
    do_reset(1'b0, 16'd0, 12'd100, 12'd50);
    rst_n = 1'b0;
    #1;
    check("rst_pause_xoff", 64'(fc.pause_xoff), 64'h0);
    check("rst_pause_xon", 64'(fc.pause_xon), 64'h0);
    check("rst_pfc_xoff", 64'(fc.pfc_xoff), 64'h0);
    check("rst_xoff_state", 64'(fc.xoff_state), 64'h0);
    check("rst_xoff_events", 64'(fc.xoff_events), 64'h0);

    // Link-mode hysteresis and pulses on ch0 prio3
    do_reset(1'b0, 16'd0, 12'd100, 12'd50);
    for (int i = 0; i < 15; i++) begin
      set_fill(0, 3, tbl[i].fill);
      tick();
      check($sformatf("tbl%0d_state", i), 64'(fc.xoff_state[3]), 64'(tbl[i].st));
      check($sformatf("tbl%0d_pxoff", i), 64'(fc.pause_xoff), 64'(tbl[i].pxoff));
      check($sformatf("tbl%0d_pxon", i), 64'(fc.pause_xon), 64'(tbl[i].pxon));
      check($sformatf("tbl%0d_evt", i), 64'(evt(0)), 64'(tbl[i].evt));
    end

    // XOFF refresh every 10 cycles on ch2
    do_reset(1'b0, 16'd10, 12'd100, 12'd50);
    set_fill(2, 0, 12'd200);
    for (int t = 1; t <= 35; t++) begin
      tick();
      check($sformatf("refresh_xoff_t%0d", t), 64'(fc.pause_xoff),
            (t == 2 || t == 12 || t == 22 || t == 32) ? 64'h4 : 64'h0);
      check($sformatf("refresh_xon_t%0d", t), 64'(fc.pause_xon), 64'h0);
    end

    // PFC mode on ch1
    do_reset(1'b1, 16'd0, 12'd100, 12'd50);
    set_fill(1, 5, 12'd120);
    set_fill(1, 2, 12'd120);
    tick();
    check("pfc_lat1", 64'(fc.pfc_xoff[15:8]), 64'h00);
    tick();
    check("pfc_lat2", 64'(fc.pfc_xoff[15:8]), 64'h24);
    check("pfc_evt", 64'(evt(1)), 64'd1);
    check("pfc_no_pause", 64'(fc.pause_xoff | fc.pause_xon), 64'h0);
    set_fill(1, 5, 12'd0);
    tick();
    check("pfc_drop_hold", 64'(fc.pfc_xoff[15:8]), 64'h24);
    tick();
    check("pfc_drop", 64'(fc.pfc_xoff[15:8]), 64'h04);
    check("pfc_evt_after_drop", 64'(evt(1)), 64'd1);

    // Mode switch while in HOLD on ch0
    do_reset(1'b0, 16'd0, 12'd100, 12'd50);
    set_fill(0, 0, 12'd200);
    tick();
    tick();
    check("mode_first_xoff", 64'(fc.pause_xoff), 64'h1);
    tick();
    tick();
    fc.cfg_pfc_mode = 1'b1;
    tick();
    check("mode_xon", 64'(fc.pause_xon), 64'h1);
    check("mode_pfc", 64'(fc.pfc_xoff[7:0]), 64'h01);
    for (int t = 0; t < 3; t++) begin
      tick();
      check("mode_quiet", 64'({fc.pause_xoff, fc.pause_xon}), 64'h0);
    end
    check("mode_evt", 64'(evt(0)), 64'd2);
    fc.cfg_pfc_mode = 1'b0;
    tick();
    check("back_link_pfc_clr", 64'(fc.pfc_xoff), 64'h0);
    check("back_link_xoff", 64'(fc.pause_xoff), 64'h1);
    check("back_link_evt", 64'(evt(0)), 64'd3);
    tick();
    tick();
    fc.cfg_enable = 1'b0;
    tick();
    check("en_fall_xon", 64'(fc.pause_xon), 64'h1);
    check("en_fall_state", 64'(fc.xoff_state), 64'h0);
    tick();
    check("en_fall_quiet", 64'({fc.pause_xoff, fc.pause_xon}), 64'h0);

    // Misconfigured xon >= xoff on ch3 prio7, then reset mid-HOLD
    do_reset(1'b0, 16'd0, 12'd100, 12'd150);
    for (int t = 0; t < 24; t++) begin
      set_fill(3, 7, ((t / 4) % 2 == 0) ? 12'd99 : 12'd100);
      tick();
      check($sformatf("misconf_t%0d", t), 64'(fc.xoff_state[31]),
            64'((t / 4) % 2 == 1));
    end
    set_fill(3, 7, 12'd200);
    tick();
    tick();
    tick();
    check("pre_rst_state", 64'(fc.xoff_state[31]), 64'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", 64'({fc.pause_xoff, fc.pause_xon, fc.pfc_xoff}), 64'h0);
    check("async_rst_state", 64'(fc.xoff_state), 64'h0);
    check("async_rst_evt", 64'(fc.xoff_events), 64'h0);

    // Counter saturation via PFC edges on ch2
    do_reset(1'b1, 16'd0, 12'd100, 12'd50);
    for (int k = 0; k < 259; k++) begin
      set_fill(2, 1, 12'd200);
      tick();
      set_fill(2, 1, 12'd0);
      tick();
      if (k == 99) check("sat_mid", 64'(evt(2)), 64'd100);
    end
    tick();
    tick();
    check("sat_final", 64'(evt(2)), 64'd255);
    check("sat_other_ch", 64'(evt(0)), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
